// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
package keypad_pkg;

  localparam int KEY_W    = 16;
  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;

  // Encoding 2'd3 is deliberately unused; the FSM recovers to SCAN from it.
  typedef enum logic [1:0] {
    SCAN         = 2'd0,
    DEBOUNCE     = 2'd1,
    WAIT_RELEASE = 2'd2
  } scan_state_t;

  // Processor-facing key word: upper bits zero, then row, then column.
  function automatic logic [KEY_W-1:0] pack_key(input logic [1:0] row,
                                                input logic [1:0] col);
    return {12'h000, row, col};
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Key handshake between the scanner (master) and the processor side (slave).
interface keypad_scanner_if;
  import keypad_pkg::*;

  logic [KEY_W-1:0] key_code;
  logic             key_valid;
  logic             key_ack;
  logic             overrun;

  modport master (
    output key_code,
    output key_valid,
    output overrun,
    input  key_ack
  );

  modport slave (
    input  key_code,
    input  key_valid,
    input  overrun,
    output key_ack
  );

endinterface

// File: rtl/keypad_row_sync.sv
// Two-flop synchroniser for the asynchronous keypad row returns.
// Resets to all ones so no row looks pressed coming out of reset.
module keypad_row_sync
  import keypad_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_ROWS-1:0] row_n,
  output logic [NUM_ROWS-1:0] rs
);

  for (genvar gi = 0; gi < NUM_ROWS; gi++) begin : g_bit
    logic meta_reg;
    logic sync_reg;

    // Capture the raw pin, then re-register to resolve metastability.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        meta_reg <= 1'b1;
        sync_reg <= 1'b1;
      end else begin
        meta_reg <= row_n[gi];
        sync_reg <= meta_reg;
      end
    end

    assign rs[gi] = sync_reg;
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: rotates the column drive, debounces a single
// pressed row, rejects ghost/multi-key patterns and holds one key code under
// a valid/ack handshake. A held key commits once; it must be released for a
// full debounce interval before it can commit again.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_CYCLES = 20000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_ROWS-1:0]  row_n,
  output logic [NUM_COLS-1:0]  col_n,
  output logic [1:0]           scan_state,
  keypad_scanner_if.master     kif
);

  localparam int SLOT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DEB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);

  logic [NUM_ROWS-1:0] rs;

  scan_state_t         state_reg,    state_next;
  logic [1:0]          col_reg,      col_next;
  logic [1:0]          cand_row_reg, cand_row_next;
  logic [SLOT_W-1:0]   slot_cnt_reg, slot_cnt_next;
  logic [DEB_W-1:0]    deb_cnt_reg,  deb_cnt_next;
  logic [KEY_W-1:0]    key_code_reg, key_code_next;
  logic                key_valid_reg, key_valid_next;
  logic                overrun_reg,  overrun_next;

  logic [2:0]          low_cnt;
  logic [1:0]          low_idx;
  logic                cand_match;
  logic                commit;

  keypad_row_sync u_row_sync (
    .clk   (clk),
    .rst   (rst),
    .row_n (row_n),
    .rs    (rs)
  );

  // Count low rows and remember which one, to tell a single key from a ghost.
  always_comb begin
    low_cnt = 3'd0;
    low_idx = 2'd0;
    for (int i = 0; i < NUM_ROWS; i++) begin
      if (!rs[i]) begin
        low_cnt = low_cnt + 3'd1;
        low_idx = 2'(i);
      end
    end
  end

  // True only when exactly the candidate row is low.
  assign cand_match = (rs == ~(NUM_ROWS'(1) << cand_row_reg));

  // Next-state, counters, commit and handshake.
  always_comb begin
    state_next     = state_reg;
    col_next       = col_reg;
    cand_row_next  = cand_row_reg;
    slot_cnt_next  = slot_cnt_reg;
    deb_cnt_next   = deb_cnt_reg;
    key_code_next  = key_code_reg;
    key_valid_next = key_valid_reg;
    overrun_next   = overrun_reg;
    commit         = 1'b0;

    case (state_reg)
      SCAN: begin
        if (slot_cnt_reg == SLOT_LAST) begin
          slot_cnt_next = '0;
          if (low_cnt == 3'd1) begin
            cand_row_next = low_idx;
            deb_cnt_next  = '0;
            state_next    = DEBOUNCE;
          end else begin
            col_next = col_reg + 2'd1;
          end
        end else begin
          slot_cnt_next = slot_cnt_reg + SLOT_W'(1);
        end
      end

      DEBOUNCE: begin
        if (cand_match) begin
          if (deb_cnt_reg == DEB_LAST) begin
            commit       = 1'b1;
            deb_cnt_next = '0;
            state_next   = WAIT_RELEASE;
          end else begin
            deb_cnt_next = deb_cnt_reg + DEB_W'(1);
          end
        end else begin
          deb_cnt_next  = '0;
          slot_cnt_next = '0;
          col_next      = col_reg + 2'd1;
          state_next    = SCAN;
        end
      end

      WAIT_RELEASE: begin
        if (rs == '1) begin
          if (deb_cnt_reg == DEB_LAST) begin
            deb_cnt_next  = '0;
            slot_cnt_next = '0;
            col_next      = col_reg + 2'd1;
            state_next    = SCAN;
          end else begin
            deb_cnt_next = deb_cnt_reg + DEB_W'(1);
          end
        end else begin
          deb_cnt_next = '0;
        end
      end

      default: begin
        deb_cnt_next  = '0;
        slot_cnt_next = '0;
        state_next    = SCAN;
      end
    endcase

    // Consume: ack only counts while a key is actually pending.
    if (kif.key_ack && key_valid_reg) begin
      key_valid_next = 1'b0;
      overrun_next   = 1'b0;
    end

    // A commit coinciding with ack replaces the consumed key.
    if (commit) begin
      if (!key_valid_reg || kif.key_ack) begin
        key_code_next  = pack_key(cand_row_reg, col_reg);
        key_valid_next = 1'b1;
      end else begin
        overrun_next = 1'b1;
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= SCAN;
      col_reg       <= 2'd0;
      cand_row_reg  <= 2'd0;
      slot_cnt_reg  <= '0;
      deb_cnt_reg   <= '0;
      key_code_reg  <= '0;
      key_valid_reg <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      col_reg       <= col_next;
      cand_row_reg  <= cand_row_next;
      slot_cnt_reg  <= slot_cnt_next;
      deb_cnt_reg   <= deb_cnt_next;
      key_code_reg  <= key_code_next;
      key_valid_reg <= key_valid_next;
      overrun_reg   <= overrun_next;
    end
  end

  assign col_n         = ~(NUM_COLS'(1) << col_reg);
  assign scan_state    = state_reg;
  assign kif.key_code  = key_code_reg;
  assign kif.key_valid = key_valid_reg;
  assign kif.overrun   = overrun_reg;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a keypad model closes row/column contacts, a
// scoreboard queue holds the keys expected to appear and a monitor pops and
// compares on every rising edge of key_valid.
module tb_keypad_scanner;
  import keypad_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  row_n;
  logic [3:0]  col_n;
  logic [1:0]  scan_state;
  logic [15:0] pressed = '0;   // bit r*4+c closes the contact row r / col c

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];

  keypad_scanner_if kif ();

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CYCLES(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .row_n      (row_n),
    .col_n      (col_n),
    .scan_state (scan_state),
    .kif        (kif)
  );

  always #5 clk = ~clk;

  // Keypad matrix: a closed contact pulls its row to the driven column level.
  always_comb begin
    row_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end else begin
      $display("ok   %s value=%0h", name, act);
    end
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic wait_valid(input string name, input int max_cycles, output int lat);
    lat = 0;
    for (int i = 1; i <= max_cycles; i++) begin
      @(negedge clk);
      if (kif.key_valid) begin
        lat = i;
        break;
      end
    end
    checks++;
    if (lat == 0) begin
      errors++;
      $display("FAIL %s timeout actual=no key_valid required=key_valid within %0d cycles", name, max_cycles);
    end
  endtask

  task automatic ack_pulse();
    @(negedge clk);
    kif.key_ack = 1'b1;
    @(negedge clk);
    kif.key_ack = 1'b0;
  endtask

  // Monitor: each new key presentation must match the head of the queue.
  initial begin
    logic        prev_valid;
    logic [15:0] exp;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && kif.key_valid && !prev_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_key actual=%h required=no key", kif.key_code);
        end else begin
          exp = exp_q.pop_front();
          if (kif.key_code !== exp) begin
            errors++;
            $display("FAIL key_code actual=%h required=%h", kif.key_code, exp);
          end else begin
            $display("key  code=%h", kif.key_code);
          end
        end
      end
      prev_valid = kif.key_valid;
    end
  end

  initial begin
    int  lat;
    bit  seen_valid;
    bit  left_scan;
    logic [3:0] cols_seen;

    kif.key_ack = 1'b0;
    cycles(3);
    rst = 1'b0;

    // Asynchronous reset in the middle of a scan slot.
    cycles(6);
    #2 rst = 1'b1;
    #1;
    chk("rst_col_n", col_n, 4'b1110);
    chk("rst_key_valid", kif.key_valid, 1'b0);
    chk("rst_key_code", kif.key_code, 16'h0000);
    chk("rst_overrun", kif.overrun, 1'b0);
    chk("rst_state", scan_state, 2'd0);
    @(negedge clk);

    // Single press row2/col1 released from reset at column 0.
    exp_q.push_back(16'h0009);
    rst = 1'b0;
    pressed[9] = 1'b1;
    wait_valid("press9_valid", 30, lat);
    chk("press9_latency_window", (lat >= 10 && lat <= 26), 1'b1);
    ack_pulse();
    chk("ack9_valid_low", kif.key_valid, 1'b0);
    chk("ack9_code_kept", kif.key_code, 16'h0009);
    pressed = '0;
    cycles(20);
    chk("after9_state", scan_state, 2'd0);

    // Bounce on row1/col3: never stable long enough to commit.
    seen_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (i % 3 == 0) pressed[7] = ~pressed[7];
      @(negedge clk);
      if (kif.key_valid) seen_valid = 1'b1;
    end
    pressed = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (kif.key_valid) seen_valid = 1'b1;
    end
    chk("bounce_no_valid", seen_valid, 1'b0);
    chk("bounce_state_scan", scan_state, 2'd0);

    // Ghost: rows 0 and 3 on column 2.
    pressed[2]  = 1'b1;
    pressed[14] = 1'b1;
    cols_seen = '0;
    left_scan = 1'b0;
    seen_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      cols_seen = cols_seen | ~col_n;
      if (scan_state != 2'd0) left_scan = 1'b1;
      if (kif.key_valid) seen_valid = 1'b1;
    end
    pressed = '0;
    chk("ghost_no_valid", seen_valid, 1'b0);
    chk("ghost_stays_scan", left_scan, 1'b0);
    chk("ghost_cols_rotate", cols_seen, 4'hF);
    cycles(4);

    // Overrun: key 5 then key 10 without ack.
    exp_q.push_back(16'h0005);
    pressed[5] = 1'b1;
    wait_valid("press5_valid", 40, lat);
    pressed = '0;
    cycles(20);
    pressed[10] = 1'b1;
    lat = 0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (kif.overrun) begin
        lat = i;
        break;
      end
    end
    chk("overrun_seen", (lat != 0), 1'b1);
    pressed = '0;
    cycles(20);
    chk("overrun_code_kept", kif.key_code, 16'h0005);
    chk("overrun_valid", kif.key_valid, 1'b1);
    chk("overrun_sticky", kif.overrun, 1'b1);
    ack_pulse();
    chk("overrun_ack_valid", kif.key_valid, 1'b0);
    chk("overrun_ack_clear", kif.overrun, 1'b0);
    cycles(4);

    // Hold key 7: one commit only, then release and press again.
    exp_q.push_back(16'h0007);
    pressed[7] = 1'b1;
    wait_valid("press7_valid", 40, lat);
    ack_pulse();
    seen_valid = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (kif.key_valid) seen_valid = 1'b1;
    end
    chk("hold7_no_repeat", seen_valid, 1'b0);
    chk("hold7_state_wait", scan_state, 2'd2);
    pressed = '0;
    cycles(20);
    exp_q.push_back(16'h0007);
    pressed[7] = 1'b1;
    wait_valid("repress7_valid", 40, lat);
    chk("repress7_code", kif.key_code, 16'h0007);
    ack_pulse();
    pressed = '0;
    cycles(20);

    // Reset while a key is pending discards it.
    exp_q.push_back(16'h0003);
    pressed[3] = 1'b1;
    wait_valid("press3_valid", 40, lat);
    #2 rst = 1'b1;
    #1;
    chk("rst2_key_valid", kif.key_valid, 1'b0);
    chk("rst2_key_code", kif.key_code, 16'h0000);
    chk("rst2_col_n", col_n, 4'b1110);
    pressed = '0;
    cycles(2);
    rst = 1'b0;
    seen_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (kif.key_valid) seen_valid = 1'b1;
    end
    chk("rst2_no_pending", seen_valid, 1'b0);
    chk("queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Drives and decodes the 4x4 matrix keypad and produces the 16-bit word that feeds the processor's KeypadInputPort.
- Scans columns, synchronises and debounces row returns, rejects ghost or multi-key presses, and holds one key code under a valid/ack handshake until the processor consumes it.
- Sits between the keypad pins and ProcessorTieUp, in the same clock domain as the processor.

Parameters:
- SCAN_DIV, 1000: clk cycles each column stays driven during scanning; must be >= 3.
- DEBOUNCE_CYCLES, 20000: consecutive stable cycles required to accept a press, and also to accept a release.

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- rst  in  1  asynchronous, active-high reset.
- row_n  in  4  keypad rows, active-low, pulled up externally; asynchronous to clk.
- col_n  out  4  column drive, one-hot active-low.
- key_code  out  16  {12'h000, row[1:0], col[1:0]}; connects to KeypadInputPort.
- key_valid  out  1  key_code holds an unconsumed key.
- key_ack  in  1  one-cycle consume pulse from the processor side.
- overrun  out  1  sticky: a key was accepted while key_valid was high and was dropped.
- scan_state  out  2  current FSM state, for debug.

Behaviour:
- Reset (asynchronous, immediate):
  - col_n=4'b1110, key_code=16'h0000, key_valid=0, overrun=0, scan_state=SCAN.
  - All counters cleared; row synchroniser flops set to 4'hF.
  - Reset asserted mid-debounce or mid-handshake discards everything; there is no pending key after release of rst.
- Row input: row_n passes through a 2-flop synchroniser. Every decision below uses the synced value rs.
- SCAN (0):
  - Column c is driven for SCAN_DIV cycles and is sampled on the slot's last cycle.
  - Exactly one bit of rs low: capture cand={row,c}, clear the counter, go to DEBOUNCE with col_n held.
  - Zero rows low, or more than one row low (ghost): advance to c+1 mod 4 and reload the slot counter.
- DEBOUNCE (1):
  - Each cycle, if rs still has only cand.row low, increment the counter.
  - Any other rs pattern returns to SCAN at column c+1.
  - When the counter reaches DEBOUNCE_CYCLES-1 with a match, commit and go to WAIT_RELEASE.
- Commit rules:
  - If key_valid==0, or key_ack is high in the same cycle: key_code<=cand and key_valid<=1. The new code wins; overrun is not set.
  - Otherwise key_code is unchanged and overrun<=1.
- WAIT_RELEASE (2):
  - col_n stays held on the candidate column.
  - rs==4'hF for DEBOUNCE_CYCLES consecutive cycles: go to SCAN at column cand.col+1.
  - Any low row resets the counter.
  - A held key therefore never produces a second commit.
- Handshake:
  - key_ack sampled high while key_valid=1: key_valid<=0 and overrun<=0 on the next edge.
  - key_code keeps its last value after ack.
  - key_ack while key_valid=0 is ignored.
- Latency: first commit occurs no earlier than 2 (sync) + DEBOUNCE_CYCLES cycles after the row is first seen low in the sampled slot.
- State encoding 3 is unused; if ever entered, the FSM goes to SCAN.
- Counter widths are $clog2 of the parameter; counters never wrap beyond terminal count.

Decomposition:
- keypad_pkg holds:
  - the state enum (SCAN=0, DEBOUNCE=1, WAIT_RELEASE=2);
  - KEY_W=16 and the NUM_ROWS/NUM_COLS=4 constants;
  - the key_code packing function.
- One sub-module, keypad_row_sync: a 4-bit 2-flop synchroniser, reset value 1s.
- The FSM, counters and handshake stay in keypad_scanner.

Test Plan (SCAN_DIV=4, DEBOUNCE_CYCLES=8; the bench model drives row_n[r]=col_n[c] for each pressed key):
- Reset: pulse rst mid-scan -> col_n=4'b1110, key_valid=0, key_code=0 without waiting for a clk edge.
- Single press row2/col1, held -> key_code=16'h0009, key_valid=1 within 4*4+2+8 cycles. Pulse key_ack -> key_valid=0 next cycle, key_code stays 16'h0009.
- Bounce on row1/col3, toggling every 3 cycles for 40 cycles then released -> key_valid never asserts, state returns to SCAN.
- Ghost: rows 0 and 3 pressed on col2 -> no commit, columns keep rotating.
- Overrun: press/release key 5 (16'h0005), then press/release key 10 with no ack -> key_code=16'h0005, overrun=1. key_ack -> key_valid=0, overrun=0.
- Hold and repress: key 7 held, ack given, held 100 more cycles -> no second key_valid. Release for 8+ cycles and press again -> key_valid=1, key_code=16'h0007.
